// File: rtl/branch_ctrl.sv
// branch_ctrl: control-flow sequencer for the RV32I core.
//
// Owns the program counter, runs the single-outstanding instruction fetch
// handshake, holds the fetched instruction for decode, and resolves
// branch / JAL / JALR from execute. Prediction is static not-taken: fetch
// always runs ahead at pc+4, and a taken, aligned result flushes and
// redirects fetch.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   imem_req_o/imem_addr_o     fetch request and address (address = PC)
//   imem_gnt_i                 request accepted this cycle
//   imem_rvalid_i/imem_rdata_i fetch response
//   if_valid_o/if_instr_o/if_pc_o, if_ready_i   decode handshake
//   br_valid_i, br_kind_i, br_funct3_i, br_pc_i, br_imm_i, br_rs1_i, br_rs2_i
//                              resolution request from execute
//   redirect_o/redirect_pc_o   one-cycle flush pulse and new fetch address
//   link_we_o/link_addr_o      one-cycle link write pulse, br_pc + 4
//   misalign_exc_o             one-cycle pulse: taken target not word-aligned
//   br_illegal_o               one-cycle pulse: branch funct3 of 2 or 3
module branch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  // instruction memory
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  // decode
  output logic        if_valid_o,
  output logic [31:0] if_instr_o,
  output logic [31:0] if_pc_o,
  input  logic        if_ready_i,
  // resolution from execute
  input  logic        br_valid_i,
  input  logic [1:0]  br_kind_i,
  input  logic [2:0]  br_funct3_i,
  input  logic [31:0] br_pc_i,
  input  logic [31:0] br_imm_i,
  input  logic [31:0] br_rs1_i,
  input  logic [31:0] br_rs2_i,
  // resolution results
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic        link_we_o,
  output logic [31:0] link_addr_o,
  output logic        misalign_exc_o,
  output logic        br_illegal_o
);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWait,
    StHold,
    StDrop
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] ipc_q, ipc_d;

  logic        redirect_q, link_we_q, misalign_q, illegal_q;
  logic [31:0] redirect_pc_q, link_addr_q;

  // ---------------------------------------------------------------------------
  // Resolution
  // ---------------------------------------------------------------------------
  logic        is_branch, is_jal, is_jalr;
  logic        cmp_eq, cmp_lt, cmp_ltu;
  logic        cond_raw, f3_bad, br_taken, taken;
  logic [31:0] target;
  logic        aligned, do_redirect;

  assign is_branch = br_valid_i && (br_kind_i == 2'b00);
  assign is_jal    = br_valid_i && (br_kind_i == 2'b01);
  assign is_jalr   = br_valid_i && (br_kind_i == 2'b10);

  assign cmp_eq  = (br_rs1_i == br_rs2_i);
  assign cmp_lt  = ($signed(br_rs1_i) < $signed(br_rs2_i));
  assign cmp_ltu = (br_rs1_i < br_rs2_i);

  // funct3[2:1] picks the comparison, funct3[0] inverts it (BNE/BGE/BGEU).
  always_comb begin
    cond_raw = 1'b0;
    f3_bad   = 1'b0;
    unique case (br_funct3_i[2:1])
      2'b00:   cond_raw = cmp_eq;
      2'b10:   cond_raw = cmp_lt;
      2'b11:   cond_raw = cmp_ltu;
      default: f3_bad   = 1'b1;
    endcase
  end

  assign br_taken = is_branch && !f3_bad && (cond_raw ^ br_funct3_i[0]);
  assign taken    = br_taken || is_jal || is_jalr;

  assign target = is_jalr ? ((br_rs1_i + br_imm_i) & 32'hFFFF_FFFE) : (br_pc_i + br_imm_i);

  assign aligned     = (target[1:0] == 2'b00);
  assign do_redirect = taken && aligned;

  // ---------------------------------------------------------------------------
  // Fetch FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    ipc_d   = ipc_q;

    unique case (state_q)
      StIdle: state_d = StReq;
      StReq: begin
        if (imem_gnt_i) state_d = StWait;
      end
      StWait: begin
        if (imem_rvalid_i) begin
          instr_d = imem_rdata_i;
          ipc_d   = pc_q;
          state_d = StHold;
        end
      end
      StHold: begin
        if (if_ready_i) begin
          pc_d    = pc_q + 32'd4;
          state_d = StReq;
        end
      end
      StDrop: begin
        if (imem_rvalid_i) state_d = StReq;
      end
      default: state_d = StIdle;
    endcase

    // A redirect overrides everything above, including a same-cycle decode
    // accept. If a response is still owed to us (granted now, or awaited and
    // not arriving this cycle) it must be swallowed in DROP before refetching.
    if (do_redirect) begin
      pc_d = target;
      if (((state_q == StWait || state_q == StDrop) && !imem_rvalid_i) ||
          (state_q == StReq && imem_gnt_i)) begin
        state_d = StDrop;
      end else begin
        state_d = StReq;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      pc_q          <= RESET_PC;
      instr_q       <= '0;
      ipc_q         <= '0;
      redirect_q    <= 1'b0;
      redirect_pc_q <= '0;
      link_we_q     <= 1'b0;
      link_addr_q   <= '0;
      misalign_q    <= 1'b0;
      illegal_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      instr_q       <= instr_d;
      ipc_q         <= ipc_d;
      redirect_q    <= do_redirect;
      redirect_pc_q <= do_redirect ? target : '0;
      link_we_q     <= is_jal || is_jalr;
      link_addr_q   <= (is_jal || is_jalr) ? (br_pc_i + 32'd4) : '0;
      misalign_q    <= taken && !aligned;
      illegal_q     <= is_branch && f3_bad;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imem_req_o     = (state_q == StReq);
  assign imem_addr_o    = pc_q;
  assign if_valid_o     = (state_q == StHold);
  assign if_instr_o     = instr_q;
  assign if_pc_o        = ipc_q;
  assign redirect_o     = redirect_q;
  assign redirect_pc_o  = redirect_pc_q;
  assign link_we_o      = link_we_q;
  assign link_addr_o    = link_addr_q;
  assign misalign_exc_o = misalign_q;
  assign br_illegal_o   = illegal_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: randomized memory/decode/execute stimulus with a
// transaction-level reference model (response queue, expected PC stream,
// presented-instruction slot) and a directed set of branch vectors up front.
module tb_branch_ctrl;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        if_ready;
  logic        br_valid;
  logic [1:0]  br_kind;
  logic [2:0]  br_funct3;
  logic [31:0] br_pc, br_imm, br_rs1, br_rs2;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        link_we;
  logic [31:0] link_addr;
  logic        misalign_exc;
  logic        br_illegal;

  branch_ctrl #(.RESET_PC(ResetPc)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_o     (imem_req),
    .imem_addr_o    (imem_addr),
    .imem_gnt_i     (imem_gnt),
    .imem_rvalid_i  (imem_rvalid),
    .imem_rdata_i   (imem_rdata),
    .if_valid_o     (if_valid),
    .if_instr_o     (if_instr),
    .if_pc_o        (if_pc),
    .if_ready_i     (if_ready),
    .br_valid_i     (br_valid),
    .br_kind_i      (br_kind),
    .br_funct3_i    (br_funct3),
    .br_pc_i        (br_pc),
    .br_imm_i       (br_imm),
    .br_rs1_i       (br_rs1),
    .br_rs2_i       (br_rs2),
    .redirect_o     (redirect),
    .redirect_pc_o  (redirect_pc),
    .link_we_o      (link_we),
    .link_addr_o    (link_addr),
    .misalign_exc_o (misalign_exc),
    .br_illegal_o   (br_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Memory image: a fixed scramble of the address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h3C5A_0F96;
  endfunction

  // Architectural resolution rules.
  function automatic void resolve(input logic [1:0] kind, input logic [2:0] f3,
                                  input logic [31:0] pc, input logic [31:0] imm,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output bit taken, output bit illegal,
                                  output logic [31:0] tgt);
    longint sa, sb, ua, ub;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    taken   = 1'b0;
    illegal = 1'b0;
    tgt     = pc + imm;
    case (kind)
      2'd0: begin
        case (f3)
          3'd0: taken = (ua == ub);
          3'd1: taken = (ua != ub);
          3'd4: taken = (sa < sb);
          3'd5: taken = (sa >= sb);
          3'd6: taken = (ua < ub);
          3'd7: taken = (ua >= ub);
          default: illegal = 1'b1;
        endcase
      end
      2'd1: taken = 1'b1;
      2'd2: begin
        taken = 1'b1;
        tgt   = (a + imm) & 32'hFFFF_FFFE;
      end
      default: ;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int unsigned due;
  } rsp_t;

  rsp_t        pend[$];
  bit          presenting;
  logic [31:0] pres_pc;
  logic [31:0] exp_pc;
  bit          idle;
  bit          e_redir, e_link, e_mis, e_ill;
  logic [31:0] e_rpc, e_laddr;
  int unsigned cyc;
  int unsigned n_acc;
  int unsigned n_dir;
  bit          rsp_pop;

  task automatic model_reset();
    pend.delete();
    presenting = 1'b0;
    pres_pc    = '0;
    exp_pc     = ResetPc;
    idle       = 1'b1;
    e_redir    = 1'b0;
    e_link     = 1'b0;
    e_mis      = 1'b0;
    e_ill      = 1'b0;
    e_rpc      = '0;
    e_laddr    = '0;
  endtask

  task automatic zero_inputs();
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if_ready    = 1'b0;
    br_valid    = 1'b0;
    br_kind     = '0;
    br_funct3   = '0;
    br_pc       = '0;
    br_imm      = '0;
    br_rs1      = '0;
    br_rs2      = '0;
    rsp_pop     = 1'b0;
  endtask

  // Directed vectors: BEQ taken, BNE not, BLT taken, BLTU not, misaligned
  // JALR, illegal funct3, JAL.
  task automatic load_directed(input int unsigned idx);
    br_valid = 1'b1;
    case (idx)
      0: begin br_kind = 2'd0; br_funct3 = 3'd0; br_pc = 32'h100; br_imm = 32'hFFFF_FFF8;
               br_rs1 = 32'd5; br_rs2 = 32'd5; end
      1: begin br_kind = 2'd0; br_funct3 = 3'd1; br_pc = 32'h100; br_imm = 32'hFFFF_FFF8;
               br_rs1 = 32'd5; br_rs2 = 32'd5; end
      2: begin br_kind = 2'd0; br_funct3 = 3'd4; br_pc = 32'h200; br_imm = 32'd16;
               br_rs1 = 32'hFFFF_FFFF; br_rs2 = 32'd1; end
      3: begin br_kind = 2'd0; br_funct3 = 3'd6; br_pc = 32'h200; br_imm = 32'd16;
               br_rs1 = 32'hFFFF_FFFF; br_rs2 = 32'd1; end
      4: begin br_kind = 2'd2; br_funct3 = 3'd0; br_pc = 32'h300; br_imm = 32'd0;
               br_rs1 = 32'h203; br_rs2 = 32'd0; end
      5: begin br_kind = 2'd0; br_funct3 = 3'd2; br_pc = 32'h400; br_imm = 32'd8;
               br_rs1 = 32'd1; br_rs2 = 32'd1; end
      default: begin br_kind = 2'd1; br_funct3 = 3'd0; br_pc = 32'h500; br_imm = 32'h40;
               br_rs1 = 32'd0; br_rs2 = 32'd0; end
    endcase
  endtask

  task automatic drive_inputs();
    int d;
    imem_gnt    = ($urandom_range(0, 9) < 7);
    if_ready    = ($urandom_range(0, 9) < 6);
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    rsp_pop     = 1'b0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = pend[0].stale ? 32'hDEAD_BEEF : mem_word(pend[0].addr);
      rsp_pop     = 1'b1;
    end else if (pend.size() == 0 && $urandom_range(0, 9) == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
    end

    br_valid = 1'b0;
    if (cyc >= 40 && $urandom_range(0, 9) < 2) begin
      if (n_dir < 7) begin
        load_directed(n_dir);
        n_dir++;
      end else begin
        br_valid  = 1'b1;
        br_kind   = 2'($urandom_range(0, 3));
        br_funct3 = 3'($urandom_range(0, 7));
        br_pc     = $urandom() & 32'hFFFF_FFFC;
        d         = int'($urandom_range(0, 63)) - 32;
        br_imm    = ($urandom_range(0, 9) < 8) ? 32'(d * 4) : $urandom();
        br_rs1    = ($urandom_range(0, 1) == 1) ? $urandom() : 32'($urandom_range(0, 15));
        if ($urandom_range(0, 9) < 8) br_rs1[1:0] = 2'b00;
        br_rs2    = ($urandom_range(0, 1) == 1) ? br_rs1 : $urandom();
      end
    end
  endtask

  // Checks outputs of the current cycle, then advances the model by one edge.
  task automatic step();
    bit          req_exp, grant, accept, taken, illegal, redir, got_new;
    logic [31:0] tgt, new_pc;
    rsp_t        r;

    check_eq("redirect", 32'(redirect), 32'(e_redir));
    if (e_redir) check_eq("redirect_pc", redirect_pc, e_rpc);
    check_eq("link_we", 32'(link_we), 32'(e_link));
    if (e_link) check_eq("link_addr", link_addr, e_laddr);
    check_eq("misalign_exc", 32'(misalign_exc), 32'(e_mis));
    check_eq("br_illegal", 32'(br_illegal), 32'(e_ill));

    check_eq("if_valid", 32'(if_valid), 32'(presenting));
    if (presenting) begin
      check_eq("if_pc", if_pc, pres_pc);
      check_eq("if_instr", if_instr, mem_word(pres_pc));
    end

    req_exp = !idle && !presenting && (pend.size() == 0);
    check_eq("imem_req", 32'(imem_req), 32'(req_exp));
    if (req_exp) check_eq("imem_addr", imem_addr, exp_pc);

    grant  = req_exp && imem_gnt;
    accept = presenting && if_ready;
    resolve(br_kind, br_funct3, br_pc, br_imm, br_rs1, br_rs2, taken, illegal, tgt);
    redir = br_valid && taken && (tgt[1:0] == 2'b00);

    if (accept) begin
      n_acc++;
      check_eq("accept_pc", pres_pc, exp_pc);
    end

    got_new = 1'b0;
    new_pc  = '0;
    if (rsp_pop) begin
      r = pend.pop_front();
      if (!r.stale && !redir) begin
        got_new = 1'b1;
        new_pc  = r.addr;
      end
    end
    if (grant) begin
      r.addr  = exp_pc;
      r.stale = 1'b0;
      r.due   = cyc + 1 + $urandom_range(0, 2);
      pend.push_back(r);
    end
    if (redir) foreach (pend[i]) pend[i].stale = 1'b1;

    if (redir) presenting = 1'b0;
    else if (got_new) begin
      presenting = 1'b1;
      pres_pc    = new_pc;
    end else if (accept) presenting = 1'b0;

    if (redir) exp_pc = tgt;
    else if (accept) exp_pc = exp_pc + 32'd4;

    e_redir = redir;
    e_rpc   = tgt;
    e_link  = br_valid && (br_kind == 2'd1 || br_kind == 2'd2);
    e_laddr = br_pc + 32'd4;
    e_mis   = br_valid && taken && (tgt[1:0] != 2'b00);
    e_ill   = br_valid && illegal;
    idle    = 1'b0;
    cyc++;
  endtask

  task automatic check_reset_outputs(input string pfx);
    check_eq({pfx, "_imem_req"}, 32'(imem_req), 32'd0);
    check_eq({pfx, "_imem_addr"}, imem_addr, ResetPc);
    check_eq({pfx, "_if_valid"}, 32'(if_valid), 32'd0);
    check_eq({pfx, "_if_instr"}, if_instr, 32'd0);
    check_eq({pfx, "_if_pc"}, if_pc, 32'd0);
    check_eq({pfx, "_redirect"}, 32'(redirect), 32'd0);
    check_eq({pfx, "_redirect_pc"}, redirect_pc, 32'd0);
    check_eq({pfx, "_link_we"}, 32'(link_we), 32'd0);
    check_eq({pfx, "_link_addr"}, link_addr, 32'd0);
    check_eq({pfx, "_misalign"}, 32'(misalign_exc), 32'd0);
    check_eq({pfx, "_illegal"}, 32'(br_illegal), 32'd0);
  endtask

  task automatic release_and_run(input int unsigned ncyc);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    drive_inputs();
    #1;
    step();
    repeat (ncyc) begin
      @(posedge clk);
      #1;
      drive_inputs();
      #1;
      step();
    end
  endtask

  initial begin
    cyc   = 0;
    n_acc = 0;
    n_dir = 0;
    rst_n = 1'b0;
    zero_inputs();
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");

    release_and_run(3000);

    // Reset while an instruction is held for decode, bounded wait.
    begin
      int unsigned waited = 0;
      while (!presenting && waited < 50) begin
        @(posedge clk);
        #1;
        drive_inputs();
        #1;
        step();
        waited++;
      end
      check_eq("hold_before_reset", 32'(presenting), 32'd1);
    end
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_rst");
    zero_inputs();
    repeat (2) @(posedge clk);

    release_and_run(2000);

    check_eq("progress", 32'(n_acc > 100), 32'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
